// File: rtl/muldiv_pkg.sv
// Shared definitions for the mult/div execute-stage sequencer.
// Optional build macro: MULDIV_DIV0_BYPASS_EN (divide-by-zero bypass).
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    MUL_BUSY = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam int          HILO_W  = 64;
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/muldiv_cnt.sv
// Saturating busy-cycle counter: clear wins over enable, sticks at all-ones.
module muldiv_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (en && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// E-stage sequencer for the iterative divider and pipelined multiplier.
// Build macro MULDIV_DIV0_BYPASS_EN: divide-by-zero skips the divider.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_validE,
  input  logic              op_is_divE,
  input  logic              op_signE,
  input  logic [31:0]       src_aE,
  input  logic [31:0]       src_bE,
  input  logic              flushE,
  input  logic              stallM,
  output logic              div_start,
  output logic              div_sign,
  input  logic              div_ready,
  input  logic [HILO_W-1:0] div_result,
  output logic              div_abort,
  output logic              mul_start,
  output logic              mul_sign,
  input  logic [HILO_W-1:0] mul_result,
  output logic              muldiv_stallE,
  output logic              hilo_we,
  output logic [HILO_W-1:0] hilo_wdata
);

  localparam int CNT_MAX = (MUL_LATENCY > DIV_TIMEOUT) ? MUL_LATENCY : DIV_TIMEOUT;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LATENCY);
  localparam logic [CNT_W-1:0] DIV_TO_C  = CNT_W'(DIV_TIMEOUT);

  state_e            state_q, state_d;
  logic [HILO_W-1:0] result_q, result_d;
  logic              sign_q, sign_d;
  logic              is_div_q, is_div_d;
  logic              accept;
  logic              cnt_clr, cnt_en;
  logic [CNT_W-1:0]  cnt;

  muldiv_cnt #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt)
  );

`ifndef MULDIV_DIV0_BYPASS_EN
  // Operands feed the units directly; only the bypass build reads them here.
  logic operands_unused;
  assign operands_unused = ^{src_aE, src_bE};
`endif

  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    sign_d        = sign_q;
    is_div_d      = is_div_q;
    div_start     = 1'b0;
    mul_start     = 1'b0;
    div_abort     = 1'b0;
    hilo_we       = 1'b0;
    muldiv_stallE = 1'b1;
    cnt_clr       = 1'b1;
    cnt_en        = 1'b0;
    accept        = 1'b0;

    unique case (state_q)
      IDLE: begin
        muldiv_stallE = 1'b0;
        if (rst && op_validE && !flushE) begin
          accept        = 1'b1;
          muldiv_stallE = 1'b1;
          sign_d        = op_signE;
          is_div_d      = op_is_divE;
          if (op_is_divE) begin
`ifdef MULDIV_DIV0_BYPASS_EN
            if (src_bE == '0) begin
              result_d = {src_aE, DIV0_LO};
              state_d  = DONE;
            end else begin
              div_start = 1'b1;
              state_d   = DIV_BUSY;
            end
`else
            div_start = 1'b1;
            state_d   = DIV_BUSY;
`endif
          end else begin
            mul_start = 1'b1;
            state_d   = MUL_BUSY;
          end
        end
      end
      MUL_BUSY: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (flushE) begin
          state_d = IDLE;
        end else if (cnt == MUL_LAT_C) begin
          result_d = mul_result;
          state_d  = DONE;
        end
      end
      DIV_BUSY: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        // Flush beats a coincident div_ready.
        if (flushE) begin
          div_abort = 1'b1;
          state_d   = IDLE;
        end else if (div_ready) begin
          result_d = div_result;
          state_d  = DONE;
        end else if (DIV_TIMEOUT != 0 && cnt == DIV_TO_C) begin
          result_d = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (flushE) begin
          state_d = IDLE;
        end else if (!stallM) begin
          hilo_we       = 1'b1;
          muldiv_stallE = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Sign qualifiers are valid alongside the start pulse and held until retire.
    div_sign = (accept &&  op_is_divE) ? op_signE : (state_q != IDLE &&  is_div_q && sign_q);
    mul_sign = (accept && !op_is_divE) ? op_signE : (state_q != IDLE && !is_div_q && sign_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      sign_q   <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      is_div_q <= is_div_d;
    end
  end

  assign hilo_wdata = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed + randomized bench for muldiv_ctrl with behavioural divider/multiplier models.
module tb_muldiv_ctrl;

  localparam int LAT = 2;
  localparam int TO  = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_validE = 1'b0, op_is_divE = 1'b0, op_signE = 1'b0;
  logic [31:0] src_aE = '0, src_bE = '0;
  logic        flushE = 1'b0, stallM = 1'b0;
  logic        div_start, div_sign, div_abort, mul_start, mul_sign;
  logic        div_ready = 1'b0;
  logic [63:0] div_result = '0, mul_result = '0;
  logic        muldiv_stallE, hilo_we;
  logic [63:0] hilo_wdata;

  muldiv_ctrl #(.MUL_LATENCY(LAT), .DIV_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .op_validE(op_validE), .op_is_divE(op_is_divE),
    .op_signE(op_signE), .src_aE(src_aE), .src_bE(src_bE), .flushE(flushE),
    .stallM(stallM), .div_start(div_start), .div_sign(div_sign),
    .div_ready(div_ready), .div_result(div_result), .div_abort(div_abort),
    .mul_start(mul_start), .mul_sign(mul_sign), .mul_result(mul_result),
    .muldiv_stallE(muldiv_stallE), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    if (s) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return 64'(sp);
    end
    up = longint'({32'b0, a}) * longint'({32'b0, b});
    return up;
  endfunction

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    int q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // Divider model: div_ready for one cycle div_lat cycles after the start cycle.
  int          div_lat = 4;
  bit          div_never = 1'b0;
  int          dleft = 0;
  logic [63:0] div_pend = '0;
  always @(posedge clk) begin
    div_ready <= 1'b0;
    if (div_start) begin
      dleft      <= div_never ? 0 : div_lat - 1;
      div_pend   <= ref_div(div_sign, src_aE, src_bE);
      div_result <= {$urandom, $urandom};
    end else if (div_abort) begin
      dleft <= 0;
    end else if (dleft == 1) begin
      div_ready  <= 1'b1;
      div_result <= div_pend;
      dleft      <= 0;
    end else if (dleft > 1) begin
      dleft <= dleft - 1;
    end
  end

  // Multiplier model: product appears LAT cycles after the start cycle and is held.
  int          mleft = 0;
  logic [63:0] mul_pend = '0;
  always @(posedge clk) begin
    if (mul_start) begin
      if (LAT == 1) mul_result <= ref_mul(mul_sign, src_aE, src_bE);
      else begin
        mul_result <= {$urandom, $urandom};
        mul_pend   <= ref_mul(mul_sign, src_aE, src_bE);
        mleft      <= LAT - 1;
      end
    end else if (mleft == 1) begin
      mul_result <= mul_pend;
      mleft      <= 0;
    end else if (mleft > 1) begin
      mleft <= mleft - 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/div_start"}, 64'(div_start), 64'd0);
    chk({tag, "/mul_start"}, 64'(mul_start), 64'd0);
    chk({tag, "/div_abort"}, 64'(div_abort), 64'd0);
    chk({tag, "/stall"},     64'(muldiv_stallE), 64'd0);
    chk({tag, "/hilo_we"},   64'(hilo_we), 64'd0);
    chk({tag, "/signs"},     64'({div_sign, mul_sign}), 64'd0);
  endtask

  // One complete op. stallM holds DONE for `hold` cycles; op_validE stays up through retire.
  task automatic run_op(input string tag, input bit is_div, input bit s,
                        input logic [31:0] a, input logic [31:0] b,
                        input int dlat, input bit never, input int hold);
    logic [63:0] exp;
    bit          bypass;
    int          cap, we_c;
    bypass = 1'b0;
`ifdef MULDIV_DIV0_BYPASS_EN
    bypass = is_div && (b == 0);
`endif
    exp  = never ? 64'd0 : (is_div ? ref_div(s, a, b) : ref_mul(s, a, b));
    cap  = !is_div ? LAT + 2 : (bypass ? 1 : (never ? TO + 2 : dlat + 1));
    we_c = cap + hold;
    div_lat   = dlat;
    div_never = never;
    for (int c = 0; c <= we_c + 1; c++) begin
      op_validE  = (c <= we_c);
      op_is_divE = is_div;
      op_signE   = s;
      src_aE     = a;
      src_bE     = b;
      flushE     = 1'b0;
      stallM     = (c < we_c);
      @(negedge clk);
      chk({tag, "/div_start"}, 64'(div_start), 64'(c == 0 && is_div && !bypass));
      chk({tag, "/mul_start"}, 64'(mul_start), 64'(c == 0 && !is_div));
      chk({tag, "/div_abort"}, 64'(div_abort), 64'd0);
      chk({tag, "/stall"},     64'(muldiv_stallE), 64'(c < we_c));
      chk({tag, "/hilo_we"},   64'(hilo_we), 64'(c == we_c));
      if (c >= cap && c <= we_c) chk({tag, "/wdata"}, hilo_wdata, exp);
      if (c <= we_c) begin
        if (is_div) chk({tag, "/div_sign"}, 64'(div_sign), 64'(s));
        else        chk({tag, "/mul_sign"}, 64'(mul_sign), 64'(s));
      end
      tick();
    end
  endtask

  // Op cancelled by flushE in cycle fc; the next op may issue in the following cycle.
  task automatic run_flush(input string tag, input bit is_div, input int dlat,
                           input int fc, input bit stm);
    div_lat   = dlat;
    div_never = 1'b0;
    for (int c = 0; c <= fc; c++) begin
      op_validE  = 1'b1;
      op_is_divE = is_div;
      op_signE   = 1'b0;
      src_aE     = $urandom;
      src_bE     = $urandom | 32'd1;
      flushE     = (c == fc) && (c != 0);
      stallM     = stm;
      @(negedge clk);
      chk({tag, "/stall"},   64'(muldiv_stallE), 64'd1);
      chk({tag, "/hilo_we"}, 64'(hilo_we), 64'd0);
      chk({tag, "/div_abort"}, 64'(div_abort), 64'(c == fc && is_div));
      tick();
    end
    flushE = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk_idle("reset");
    chk("reset/wdata", hilo_wdata, 64'd0);
    tick();

    run_op("smul_neg2x3", 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 0, 1'b0, 0);
    run_op("udiv_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 34, 1'b0, 0);

    run_flush("flush_div", 1'b1, 34, 10, 1'b0);
    run_op("div_after_flush", 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 5, 1'b0, 0);

    run_flush("flush_vs_ready", 1'b1, 6, 6, 1'b0);
    run_op("mul_after_race", 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b0, 0);

    run_flush("flush_mul", 1'b0, 0, 1, 1'b0);
    run_op("stallm_hold3", 1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1'b0, 3);

    run_flush("flush_done", 1'b0, 0, LAT + 3, 1'b1);
    run_op("div_after_done_flush", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd16, 3, 1'b0, 1);

    run_op("div_timeout", 1'b1, 1'b0, 32'd123, 32'd4, 0, 1'b1, 0);
    run_op("div_by_zero", 1'b1, 1'b0, 32'd5, 32'd0, 9, 1'b0, 0);

    // Reset in the middle of a divide; the divider's late ready must be ignored.
    div_lat    = 30;
    div_never  = 1'b0;
    op_validE  = 1'b1;
    op_is_divE = 1'b1;
    op_signE   = 1'b1;
    src_aE     = $urandom;
    src_bE     = $urandom | 32'd1;
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b0;
    op_validE = 1'b0;
    tick();
    rst = 1'b1;
    for (int c = 11; c <= 32; c++) begin
      @(negedge clk);
      chk_idle("rst_mid_div");
      chk("rst_mid_div/wdata", hilo_wdata, 64'd0);
      tick();
    end

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb,
             $urandom_range(2, 20), 1'b0, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
